bus_fabric: RTL and testbench

- Parametrised system-bus fabric for the 6502 SoC top. Replaces ad-hoc address compares and the priority data mux.
- Decodes the CPU address into NUM_SLAVES windows and drives one-hot chip selects.
- Inserts per-slave wait states and stalls the CPU with a ready handshake.
- Returns registered read data, an open-bus value for unmapped addresses, and an error pulse.

---
 rtl/bus_pkg.sv | 7 +
 rtl/bus_fabric_if.sv | 29 ++
 rtl/bus_fabric_wait_counter.sv | 24 ++
 rtl/bus_fabric.sv | 146 ++++++++++++++
 tb/tb_bus_fabric.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and limits for the system-bus fabric
package bus_pkg;
    localparam int MAX_SLAVES = 8;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} bus_state_t;
    typedef logic [3:0] waitcnt_t;
endpackage

// File: rtl/bus_fabric_if.sv
// rtl/bus_fabric_if.sv - CPU-side handshake and slave-side select/data bundle
interface bus_fabric_if #(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8
);
    logic                         cpu_valid;
    logic [ADDR_W-1:0]            cpu_addr;
    logic                         cpu_rw;
    logic [DATA_W-1:0]            cpu_wdata;
    logic [DATA_W-1:0]            cpu_rdata;
    logic                         cpu_ready;
    logic                         bus_err;
    logic [NUM_SLAVES-1:0]        slv_cs;
    logic                         slv_we;
    logic [ADDR_W-1:0]            slv_addr;
    logic [DATA_W-1:0]            slv_wdata;
    logic [NUM_SLAVES*DATA_W-1:0] slv_rdata;

    modport master (
        output cpu_valid, cpu_addr, cpu_rw, cpu_wdata, slv_rdata,
        input  cpu_rdata, cpu_ready, bus_err, slv_cs, slv_we, slv_addr, slv_wdata
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_rw, cpu_wdata, slv_rdata,
        output cpu_rdata, cpu_ready, bus_err, slv_cs, slv_we, slv_addr, slv_wdata
    );
endinterface

// File: rtl/bus_fabric_wait_counter.sv
// rtl/bus_fabric_wait_counter.sv - loadable down-counter used for slave wait states
module wait_counter
    import bus_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     load,
    input  logic     en,
    input  waitcnt_t load_val,
    output waitcnt_t value,
    output logic     zero
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en) begin
            value <= value - waitcnt_t'(1);
        end
    end

    assign zero = (value == '0);
endmodule

// File: rtl/bus_fabric.sv
// rtl/bus_fabric.sv - address-decoding bus fabric with wait states and open-bus reads
// Optional write protection of RO_MASK slaves is enabled by BUS_WRITE_PROTECT_EN.
module bus_fabric
    import bus_pkg::*;
#(
    parameter int                           NUM_SLAVES = 4,
    parameter int                           ADDR_W     = 16,
    parameter int                           DATA_W     = 8,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE       = {16'h0000, 16'h8000, 16'h0800, 16'h0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SIZE       = {16'h0000, 16'h8000, 16'h0010, 16'h0800},
    parameter logic [NUM_SLAVES*4-1:0]      WAIT       = {4'd0, 4'd0, 4'd0, 4'd2},
    parameter logic [DATA_W-1:0]            OPEN_BUS   = 8'hFF,
    parameter logic [NUM_SLAVES-1:0]        RO_MASK    = 4'b0100
) (
    input  logic         clk,
    input  logic         reset_n,
    bus_fabric_if.slave  bus
);
    if (NUM_SLAVES < 1 || NUM_SLAVES > MAX_SLAVES) begin : g_bad_num_slaves
        $error("bus_fabric: NUM_SLAVES out of range");
    end

`ifdef BUS_WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif
    localparam logic [NUM_SLAVES-1:0] WP_MASK = RO_MASK & {NUM_SLAVES{WP_EN}};

    bus_state_t            state_q, state_d;
    logic [NUM_SLAVES-1:0] hit_vec, sel_d, sel_q;
    logic [ADDR_W:0]       a_ext, b_ext, s_ext;
    logic [ADDR_W-1:0]     base_d, addr_q;
    logic [DATA_W-1:0]     wdata_q, rdata_q, rd_sel;
    waitcnt_t              wait_d, cnt_value;
    logic                  cnt_zero, rw_q, fault_q;
    logic                  accepting, accept, blocked, map_ok;

    // Compare in ADDR_W+1 bits so windows reaching the top of memory never wrap.
    always_comb begin
        hit_vec = '0;
        a_ext   = {1'b0, bus.cpu_addr};
        b_ext   = '0;
        s_ext   = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            b_ext      = {1'b0, BASE[i*ADDR_W +: ADDR_W]};
            s_ext      = {1'b0, SIZE[i*ADDR_W +: ADDR_W]};
            hit_vec[i] = (s_ext != '0) && (a_ext >= b_ext) && ((a_ext - b_ext) < s_ext);
        end
        // Isolate the lowest set bit: lowest index wins on overlap.
        sel_d  = hit_vec & ((~hit_vec) + NUM_SLAVES'(1));
        wait_d = '0;
        base_d = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_d[i]) begin
                wait_d = WAIT[i*4 +: 4];
                base_d = BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign blocked   = bus.cpu_rw && |(sel_d & WP_MASK);
    assign map_ok    = |sel_d && !blocked;
    assign accepting = (state_q == IDLE) || (state_q == DONE);
    assign accept    = accepting && bus.cpu_valid;

    wait_counter u_wait_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept && map_ok),
        .en       ((state_q == ACCESS) && (cnt_value != '0)),
        .load_val (wait_d),
        .value    (cnt_value),
        .zero     (cnt_zero)
    );

    always_comb begin
        rd_sel = OPEN_BUS;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) rd_sel = bus.slv_rdata[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = map_ok ? ACCESS : DONE;
        end else begin
            case (state_q)
                ACCESS:  if (cnt_zero) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q   <= '0;
            rw_q    <= 1'b0;
            fault_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= OPEN_BUS;
        end else if (accept) begin
            sel_q   <= map_ok ? sel_d : '0;
            rw_q    <= bus.cpu_rw;
            fault_q <= !map_ok;
            addr_q  <= bus.cpu_addr - base_d;
            wdata_q <= bus.cpu_wdata;
            if (!map_ok && !bus.cpu_rw) rdata_q <= OPEN_BUS;
        end else if ((state_q == ACCESS) && cnt_zero && !rw_q) begin
            rdata_q <= rd_sel;
        end
    end

    always_comb begin
        bus.slv_cs    = '0;
        bus.slv_we    = 1'b0;
        bus.cpu_ready = 1'b0;
        bus.bus_err   = 1'b0;
        case (state_q)
            ACCESS: begin
                bus.slv_cs = sel_q;
                bus.slv_we = rw_q;
            end
            DONE: begin
                bus.cpu_ready = 1'b1;
                bus.bus_err   = fault_q;
            end
            default: ;
        endcase
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.slv_addr  = addr_q;
    assign bus.slv_wdata = wdata_q;
endmodule

// File: tb/tb_bus_fabric.sv
// tb/tb_bus_fabric.sv - scoreboard bench for bus_fabric (default map plus an overlapping-window instance)
module tb_bus_fabric;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_valid, cpu_rw, use_ov;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata, last_rdata;
    logic [31:0] slv_rdata;
    int          checks = 0;
    int          fails  = 0;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
        logic [3:0] cs;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bus_fabric_if #(.NUM_SLAVES(4), .ADDR_W(16), .DATA_W(8)) bif ();
    bus_fabric_if #(.NUM_SLAVES(4), .ADDR_W(16), .DATA_W(8)) bov ();

    assign bif.cpu_valid = cpu_valid;
    assign bif.cpu_addr  = cpu_addr;
    assign bif.cpu_rw    = cpu_rw;
    assign bif.cpu_wdata = cpu_wdata;
    assign bif.slv_rdata = slv_rdata;
    assign bov.cpu_valid = cpu_valid;
    assign bov.cpu_addr  = cpu_addr;
    assign bov.cpu_rw    = cpu_rw;
    assign bov.cpu_wdata = cpu_wdata;
    assign bov.slv_rdata = slv_rdata;

    bus_fabric #(.NUM_SLAVES(4), .ADDR_W(16), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bif)
    );

    bus_fabric #(
        .NUM_SLAVES(4), .ADDR_W(16), .DATA_W(8),
        .BASE({16'h0800, 16'h8000, 16'h0800, 16'h0000}),
        .SIZE({16'h0100, 16'h8000, 16'h0010, 16'h0800})
    ) dut_ov (
        .clk(clk), .reset_n(reset_n), .bus(bov)
    );

    logic [7:0]  o_rdata, o_swdata;
    logic        o_ready, o_err, o_we;
    logic [3:0]  o_cs;
    logic [15:0] o_saddr;
    assign o_rdata  = use_ov ? bov.cpu_rdata : bif.cpu_rdata;
    assign o_ready  = use_ov ? bov.cpu_ready : bif.cpu_ready;
    assign o_err    = use_ov ? bov.bus_err   : bif.bus_err;
    assign o_we     = use_ov ? bov.slv_we    : bif.slv_we;
    assign o_cs     = use_ov ? bov.slv_cs    : bif.slv_cs;
    assign o_saddr  = use_ov ? bov.slv_addr  : bif.slv_addr;
    assign o_swdata = use_ov ? bov.slv_wdata : bif.slv_wdata;

    task automatic do_access(input logic [15:0] addr, input logic rw, input logic [7:0] wd,
                             output int lat, output logic [7:0] rd, output logic err,
                             output logic [3:0] cs_or, output int cs_cyc, output int we_cyc,
                             output logic [15:0] sa, output logic [7:0] sw);
        bit done = 0;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_addr = addr; cpu_rw = rw; cpu_wdata = wd;
        lat = 0; rd = '0; err = 1'b0; cs_or = '0; cs_cyc = 0; we_cyc = 0; sa = '0; sw = '0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            cpu_valid = 1'b0;
            cs_or |= o_cs;
            if (o_cs != '0) begin cs_cyc++; sa = o_saddr; sw = o_swdata; end
            if (o_we) we_cyc++;
            if (o_ready) begin rd = o_rdata; err = o_err; done = 1; end
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cpu_valid = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        use_ov = 1'b0; slv_rdata = {8'h77, 8'hA5, 8'h11, 8'h5A};
        repeat (2) @(negedge clk);
        checks++; if (o_cs !== 4'b0)    begin fails++; $display("FAIL reset_cs got %b want 0000", o_cs); end
        checks++; if (o_we !== 1'b0 || o_ready !== 1'b0 || o_err !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl got we=%b ready=%b err=%b want 0", o_we, o_ready, o_err); end
        checks++; if (o_rdata !== 8'hFF) begin fails++; $display("FAIL reset_rdata got %h want ff", o_rdata); end
        checks++; if (o_saddr !== 16'h0 || o_swdata !== 8'h0) begin
            fails++; $display("FAIL reset_slv got addr=%h wdata=%h want 0", o_saddr, o_swdata); end
        reset_n = 1'b1;
        last_rdata = 8'hFF;
    endtask

    task automatic test_read_slave2;
        exp_t e; int lat, cc, wc; logic [7:0] rd, sw; logic err; logic [3:0] cs; logic [15:0] sa;
        sb.push_back('{8'hA5, 1'b0, 2, 4'b0100});
        do_access(16'h8123, 1'b0, 8'h00, lat, rd, err, cs, cc, wc, sa, sw);
        e = sb.pop_front(); last_rdata = e.rdata;
        checks++; if (lat !== e.lat) begin fails++; $display("FAIL rd2_latency got %0d want %0d", lat, e.lat); end
        checks++; if (rd !== e.rdata) begin fails++; $display("FAIL rd2_rdata got %h want %h", rd, e.rdata); end
        checks++; if (err !== e.err || cs !== e.cs || cc != 1) begin
            fails++; $display("FAIL rd2_cs got err=%b cs=%b cycles=%0d want err=0 cs=0100 cycles=1", err, cs, cc); end
        checks++; if (sa !== 16'h0123) begin fails++; $display("FAIL rd2_slv_addr got %h want 0123", sa); end
    endtask

    task automatic test_write_slave0;
        exp_t e; int lat, cc, wc; logic [7:0] rd, sw; logic err; logic [3:0] cs; logic [15:0] sa;
        sb.push_back('{last_rdata, 1'b0, 4, 4'b0001});
        do_access(16'h0010, 1'b1, 8'h3C, lat, rd, err, cs, cc, wc, sa, sw);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin fails++; $display("FAIL wr0_latency got %0d want %0d", lat, e.lat); end
        checks++; if (cs !== e.cs || cc != 3 || wc != 3) begin
            fails++; $display("FAIL wr0_cs got cs=%b cs_cycles=%0d we_cycles=%0d want 0001/3/3", cs, cc, wc); end
        checks++; if (sw !== 8'h3C || sa !== 16'h0010) begin
            fails++; $display("FAIL wr0_slv got wdata=%h addr=%h want 3c/0010", sw, sa); end
        checks++; if (rd !== e.rdata || err !== e.err) begin
            fails++; $display("FAIL wr0_rdata got %h err=%b want %h err=0", rd, err, e.rdata); end
    endtask

    task automatic test_unmapped_and_edges;
        exp_t e; int lat, cc, wc; logic [7:0] rd, sw; logic err; logic [3:0] cs; logic [15:0] sa;
        logic [15:0] addrs [4] = '{16'h0900, 16'h0810, 16'hFFFF, 16'h07FF};
        sb.push_back('{8'hFF, 1'b1, 1, 4'b0000});
        sb.push_back('{8'hFF, 1'b1, 1, 4'b0000});
        sb.push_back('{8'hA5, 1'b0, 2, 4'b0100});
        sb.push_back('{8'h5A, 1'b0, 4, 4'b0001});
        foreach (addrs[k]) begin
            do_access(addrs[k], 1'b0, 8'h00, lat, rd, err, cs, cc, wc, sa, sw);
            e = sb.pop_front(); last_rdata = e.rdata;
            checks++; if (lat !== e.lat || err !== e.err) begin
                fails++; $display("FAIL edge_%h_timing got lat=%0d err=%b want lat=%0d err=%b", addrs[k], lat, err, e.lat, e.err); end
            checks++; if (rd !== e.rdata || cs !== e.cs) begin
                fails++; $display("FAIL edge_%h_data got rdata=%h cs=%b want %h/%b", addrs[k], rd, cs, e.rdata, e.cs); end
        end
        sb.push_back('{last_rdata, 1'b1, 1, 4'b0000});
        do_access(16'h4000, 1'b1, 8'h66, lat, rd, err, cs, cc, wc, sa, sw);
        e = sb.pop_front();
        checks++; if (lat !== e.lat || err !== e.err || cs !== e.cs || wc != 0 || rd !== e.rdata) begin
            fails++; $display("FAIL unmapped_write got lat=%0d err=%b cs=%b we=%0d rdata=%h want 1/1/0000/0/%h", lat, err, cs, wc, rd, e.rdata); end
    endtask

    task automatic test_overlap;
        exp_t e; int lat, cc, wc; logic [7:0] rd, sw; logic err; logic [3:0] cs; logic [15:0] sa;
        use_ov = 1'b1;
        sb.push_back('{8'h11, 1'b0, 2, 4'b0010});
        do_access(16'h0805, 1'b0, 8'h00, lat, rd, err, cs, cc, wc, sa, sw);
        e = sb.pop_front();
        checks++; if (cs !== e.cs || rd !== e.rdata || sa !== 16'h0005) begin
            fails++; $display("FAIL overlap_low got cs=%b rdata=%h addr=%h want 0010/11/0005", cs, rd, sa); end
        sb.push_back('{8'h77, 1'b0, 2, 4'b1000});
        do_access(16'h0850, 1'b0, 8'h00, lat, rd, err, cs, cc, wc, sa, sw);
        e = sb.pop_front();
        checks++; if (cs !== e.cs || rd !== e.rdata || sa !== 16'h0050 || lat !== e.lat) begin
            fails++; $display("FAIL overlap_s3 got cs=%b rdata=%h addr=%h lat=%0d want 1000/77/0050/2", cs, rd, sa, lat); end
        use_ov = 1'b0;
    endtask

    task automatic test_back_to_back;
        exp_t e; int cyc = 0, n = 0, r1 = 0, r2 = 0;
        sb.push_back('{8'h11, 1'b0, 2, 4'b0010});
        sb.push_back('{8'hA5, 1'b0, 2, 4'b0100});
        @(negedge clk);
        cpu_valid = 1'b1; cpu_rw = 1'b0; cpu_addr = 16'h0800;
        while (n < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (o_ready) begin
                e = sb.pop_front(); last_rdata = e.rdata;
                checks++; if (o_rdata !== e.rdata || o_err !== e.err) begin
                    fails++; $display("FAIL b2b_%0d got rdata=%h err=%b want %h/0", n, o_rdata, o_err, e.rdata); end
                if (n == 0) begin r1 = cyc; cpu_addr = 16'h8000; end
                else begin r2 = cyc; cpu_valid = 1'b0; end
                n++;
            end
        end
        cpu_valid = 1'b0;
        checks++; if (n != 2 || r1 != 2 || r2 - r1 != 2) begin
            fails++; $display("FAIL b2b_spacing got pulses=%0d first=%0d gap=%0d want 2/2/2", n, r1, r2 - r1); end
    endtask

    task automatic test_reset_mid_access;
        exp_t e; int lat, cc, wc, rdy = 0; logic [7:0] rd, sw; logic err; logic [3:0] cs; logic [15:0] sa;
        @(negedge clk);
        cpu_valid = 1'b1; cpu_rw = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h99;
        @(negedge clk);
        cpu_valid = 1'b0;
        checks++; if (o_cs !== 4'b0001) begin fails++; $display("FAIL midrst_pre_cs got %b want 0001", o_cs); end
        reset_n = 1'b0;
        #1;
        checks++; if (o_cs !== 4'b0 || o_we !== 1'b0) begin
            fails++; $display("FAIL midrst_cs got cs=%b we=%b want 0000/0", o_cs, o_we); end
        repeat (2) begin @(negedge clk); if (o_ready) rdy++; end
        reset_n = 1'b1;
        repeat (3) begin @(negedge clk); if (o_ready) rdy++; end
        checks++; if (rdy != 0 || o_rdata !== 8'hFF) begin
            fails++; $display("FAIL midrst_ready got ready_pulses=%0d rdata=%h want 0/ff", rdy, o_rdata); end
        sb.push_back('{8'hA5, 1'b0, 2, 4'b0100});
        do_access(16'h8123, 1'b0, 8'h00, lat, rd, err, cs, cc, wc, sa, sw);
        e = sb.pop_front(); last_rdata = e.rdata;
        checks++; if (lat !== e.lat || rd !== e.rdata || cs !== e.cs || err !== e.err) begin
            fails++; $display("FAIL midrst_after got lat=%0d rdata=%h cs=%b err=%b want 2/a5/0100/0", lat, rd, cs, err); end
    endtask

    task automatic test_write_protect;
        exp_t e; int lat, cc, wc; logic [7:0] rd, sw; logic err; logic [3:0] cs; logic [15:0] sa;
`ifdef BUS_WRITE_PROTECT_EN
        sb.push_back('{last_rdata, 1'b1, 1, 4'b0000});
`else
        sb.push_back('{last_rdata, 1'b0, 2, 4'b0100});
`endif
        do_access(16'h8000, 1'b1, 8'h42, lat, rd, err, cs, cc, wc, sa, sw);
        e = sb.pop_front();
        checks++; if (lat !== e.lat || err !== e.err || cs !== e.cs) begin
            fails++; $display("FAIL wprot got lat=%0d err=%b cs=%b want %0d/%b/%b", lat, err, cs, e.lat, e.err, e.cs); end
        checks++; if (wc != ((e.cs != 0) ? 1 : 0) || rd !== e.rdata) begin
            fails++; $display("FAIL wprot_we got we_cycles=%0d rdata=%h want %0d/%h", wc, rd, (e.cs != 0) ? 1 : 0, e.rdata); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_slave2();
        test_write_slave0();
        test_unmapped_and_edges();
        test_overlap();
        test_back_to_back();
        test_reset_mid_access();
        test_write_protect();
        checks++; if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
